// File: rtl/matrix_calc_dispatcher.sv
// Matrix operation dispatcher: latches an operation request, launches the
// matching compute unit with a one-hot pulse, then waits for that unit to
// complete, fail, time out or be aborted, and reports the outcome.
module matrix_calc_dispatcher #(
    parameter int DATA_W      = 32,
    parameter int ID_W        = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        calc_type,
    input  logic [ID_W-1:0]   id_a,
    input  logic [ID_W-1:0]   id_b,
    input  logic [DATA_W-1:0] scalar_in,
    input  logic              abort,
    output logic [4:0]        unit_start,
    output logic [ID_W-1:0]   unit_id_a,
    output logic [ID_W-1:0]   unit_id_b,
    output logic [DATA_W-1:0] unit_scalar,
    input  logic [4:0]        unit_done,
    input  logic [4:0]        unit_err,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT_UNIT,
        S_FINISH,
        S_FAIL
    } state_t;

    localparam logic [2:0] OP_TRANSPOSE  = 3'd0;
    localparam logic [2:0] OP_SCALAR_MUL = 3'd3;
    localparam logic [2:0] OP_LAST       = 3'd4;

    localparam logic [2:0] EC_NONE    = 3'd0;
    localparam logic [2:0] EC_ILLEGAL = 3'd1;
    localparam logic [2:0] EC_TIMEOUT = 3'd2;
    localparam logic [2:0] EC_UNIT    = 3'd3;
    localparam logic [2:0] EC_ABORT   = 3'd4;

    localparam int CNT_W = 16;
    // One bit wider than the counter so the limit compare cannot wrap.
    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYC);

    state_t              state_q, state_d;
    logic [2:0]          type_q, type_d;
    logic [ID_W-1:0]     id_a_q, id_a_d;
    logic [ID_W-1:0]     id_b_q, id_b_d;
    logic [DATA_W-1:0]   scalar_q, scalar_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          err_code_q, err_code_d;

    logic [4:0]          sel;
    logic                act_done;
    logic                act_err;
    logic                cnt_hit;

    // One-hot select of the latched operation; illegal codes select nothing.
    always_comb begin
        sel = '0;
        case (type_q)
            3'd0:    sel = 5'b00001;
            3'd1:    sel = 5'b00010;
            3'd2:    sel = 5'b00100;
            3'd3:    sel = 5'b01000;
            3'd4:    sel = 5'b10000;
            default: sel = '0;
        endcase
    end

    // Only the active unit's done/err bits matter; err counts only with done.
    assign act_done = |(unit_done & sel);
    assign act_err  = |(unit_done & unit_err & sel);
    // True in the WAIT_UNIT cycle where the counter reaches the limit.
    assign cnt_hit  = (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == TIMEOUT_LIM);

    // Next-state logic: abort beats everything, completion beats timeout.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        id_a_d     = id_a_q;
        id_b_d     = id_b_q;
        scalar_d   = scalar_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    type_d     = calc_type;
                    id_a_d     = id_a;
                    id_b_d     = (calc_type == OP_TRANSPOSE || calc_type == OP_SCALAR_MUL)
                                 ? '0 : id_b;
                    scalar_d   = (calc_type == OP_SCALAR_MUL) ? scalar_in : '0;
                    err_code_d = EC_NONE;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    err_code_d = EC_ABORT;
                    state_d    = S_FAIL;
                end else if (type_q > OP_LAST) begin
                    err_code_d = EC_ILLEGAL;
                    state_d    = S_FAIL;
                end else begin
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d = '0;
                if (abort) begin
                    err_code_d = EC_ABORT;
                    state_d    = S_FAIL;
                end else begin
                    state_d    = S_WAIT_UNIT;
                end
            end
            S_WAIT_UNIT: begin
                cnt_d = cnt_q + 1'b1;
                if (abort) begin
                    err_code_d = EC_ABORT;
                    state_d    = S_FAIL;
                end else if (act_done) begin
                    if (act_err) begin
                        err_code_d = EC_UNIT;
                        state_d    = S_FAIL;
                    end else begin
                        state_d    = S_FINISH;
                    end
                end else if (cnt_hit) begin
                    err_code_d = EC_TIMEOUT;
                    state_d    = S_FAIL;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and operand registers; reset drops straight to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            type_q     <= '0;
            id_a_q     <= '0;
            id_b_q     <= '0;
            scalar_q   <= '0;
            cnt_q      <= '0;
            err_code_q <= EC_NONE;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            id_a_q     <= id_a_d;
            id_b_q     <= id_b_d;
            scalar_q   <= scalar_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        unit_start = (state_q == S_LAUNCH) ? sel : 5'b0;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FINISH);
        err        = (state_q == S_FAIL);
    end

    assign unit_id_a   = id_a_q;
    assign unit_id_b   = id_b_q;
    assign unit_scalar = scalar_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_matrix_calc_dispatcher.sv
// Scoreboard bench for matrix_calc_dispatcher: directed stimulus pushes
// expected launches and outcomes; negedge monitors pop and compare.
module tb_matrix_calc_dispatcher;

    localparam int DATA_W = 32;
    localparam int ID_W   = 3;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        calc_type = '0;
    logic [ID_W-1:0]   id_a = '0;
    logic [ID_W-1:0]   id_b = '0;
    logic [DATA_W-1:0] scalar_in = '0;
    logic              abort = 1'b0;
    logic [4:0]        unit_start;
    logic [ID_W-1:0]   unit_id_a;
    logic [ID_W-1:0]   unit_id_b;
    logic [DATA_W-1:0] unit_scalar;
    logic [4:0]        unit_done = '0;
    logic [4:0]        unit_err = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        err_code;

    matrix_calc_dispatcher #(.DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .calc_type(calc_type),
        .id_a(id_a), .id_b(id_b), .scalar_in(scalar_in), .abort(abort),
        .unit_start(unit_start), .unit_id_a(unit_id_a), .unit_id_b(unit_id_b),
        .unit_scalar(unit_scalar), .unit_done(unit_done), .unit_err(unit_err),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [2:0]  code;
        logic [2:0]  ida;
        logic [2:0]  idb;
        logic [31:0] sc;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [4:0] vec;
        int         cyc;
    } us_t;

    exp_t exp_q[$];
    us_t  us_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Outcome monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL outcome: unexpected pulse done=%0b err=%0b code=%0d at cyc %0d",
                         done, err, err_code, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (done !== !e.is_err || err !== e.is_err || err_code !== e.code ||
                    unit_id_a !== e.ida || unit_id_b !== e.idb ||
                    unit_scalar !== e.sc || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL outcome: got done=%0b err=%0b code=%0d a=%0d b=%0d sc=%h cyc=%0d, want err=%0b code=%0d a=%0d b=%0d sc=%h cyc=%0d",
                             done, err, err_code, unit_id_a, unit_id_b, unit_scalar, cyc,
                             e.is_err, e.code, e.ida, e.idb, e.sc, e.cyc);
                end
            end
        end
    end

    // Launch monitor: every unit_start pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && unit_start != 5'b0) begin
            n_chk++;
            if (us_q.size() == 0) begin
                n_fail++;
                $display("FAIL launch: unexpected unit_start=%b at cyc %0d", unit_start, cyc);
            end else begin
                us_t u;
                u = us_q.pop_front();
                if (unit_start !== u.vec || cyc != u.cyc) begin
                    n_fail++;
                    $display("FAIL launch: got %b at cyc %0d, want %b at cyc %0d",
                             unit_start, cyc, u.vec, u.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic push_exp(input bit is_err, input logic [2:0] code, input logic [2:0] ida,
                            input logic [2:0] idb, input logic [31:0] sc, input int c);
        exp_t e;
        e.is_err = is_err; e.code = code; e.ida = ida; e.idb = idb; e.sc = sc; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_us(input logic [4:0] vec, input int c);
        us_t u;
        u.vec = vec; u.cyc = c;
        us_q.push_back(u);
    endtask

    // Drives start for one cycle; s is the cycle in which start is high.
    task automatic do_start(input logic [2:0] ct, input logic [2:0] a, input logic [2:0] b,
                            input logic [31:0] sc, output int s);
        @(posedge clk); #1;
        start = 1'b1; calc_type = ct; id_a = a; id_b = b; scalar_in = sc;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse(input logic [4:0] dn, input logic [4:0] er);
        unit_done = dn; unit_err = er;
        @(posedge clk); #1;
        unit_done = '0; unit_err = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        int guard;

        // Reset state.
        #2;
        chk("reset_outputs", {unit_start, unit_id_a, unit_id_b, unit_scalar, busy, done, err, err_code},
            64'h0);
        idle(3);
        rst = 1'b0;
        idle(2);

        // ADD: launch at +2, done at +10 -> done pulse at +11.
        do_start(3'd1, 3'd2, 3'd5, 32'hDEAD_BEEF, s);
        push_us(5'b00010, s + 2);
        push_exp(1'b0, 3'd0, 3'd2, 3'd5, 32'h0, s + 11);
        wait_to(s + 3);
        chk("add_busy", {63'h0, busy}, 64'h1);
        wait_to(s + 10);
        pulse(5'b00010, 5'b00000);
        idle(3);

        // Abort while idle has no effect.
        abort = 1'b1; idle(1); abort = 1'b0; idle(2);
        chk("idle_abort_busy", {63'h0, busy}, 64'h0);
        chk("idle_abort_code", {61'h0, err_code}, 64'h0);

        // Illegal calc_type: err at +2, no launch.
        do_start(3'd6, 3'd4, 3'd1, 32'h7B, s);
        push_exp(1'b1, 3'd1, 3'd4, 3'd1, 32'h0, s + 2);
        idle(4);
        chk("illegal_code_held", {61'h0, err_code}, 64'h1);

        // MUL timeout: 8 wait cycles (+3..+10) then err at +11.
        do_start(3'd2, 3'd1, 3'd2, 32'h0, s);
        push_us(5'b00100, s + 2);
        push_exp(1'b1, 3'd2, 3'd1, 3'd2, 32'h0, s + 11);
        idle(14);

        // MUL completion in the timeout cycle wins.
        do_start(3'd2, 3'd6, 3'd3, 32'h0, s);
        push_us(5'b00100, s + 2);
        push_exp(1'b0, 3'd0, 3'd6, 3'd3, 32'h0, s + 11);
        wait_to(s + 10);
        pulse(5'b00100, 5'b00000);
        idle(3);
        chk("race_code", {61'h0, err_code}, 64'h0);

        // CONV unit error; spurious non-active done/err is ignored.
        do_start(3'd4, 3'd7, 3'd3, 32'h55, s);
        push_us(5'b10000, s + 2);
        push_exp(1'b1, 3'd3, 3'd7, 3'd3, 32'h0, s + 7);
        wait_to(s + 4);
        pulse(5'b00001, 5'b10001);
        wait_to(s + 6);
        pulse(5'b10000, 5'b10000);
        idle(3);

        // TRANSPOSE: id_b forced to 0, done in first wait cycle.
        do_start(3'd0, 3'd5, 3'd6, 32'h99, s);
        push_us(5'b00001, s + 2);
        push_exp(1'b0, 3'd0, 3'd5, 3'd0, 32'h0, s + 4);
        wait_to(s + 3);
        pulse(5'b00001, 5'b00000);
        idle(3);

        // SCALAR_MUL: second start while busy ignored, then abort.
        do_start(3'd3, 3'd3, 3'd6, 32'hFFFF_FFFE, s);
        push_us(5'b01000, s + 2);
        push_exp(1'b1, 3'd4, 3'd3, 3'd0, 32'hFFFF_FFFE, s + 6);
        wait_to(s + 4);
        start = 1'b1; calc_type = 3'd1; id_a = 3'd7; id_b = 3'd7; scalar_in = 32'h5;
        idle(1);
        start = 1'b0;
        chk("busy_start_ida", {61'h0, unit_id_a}, 64'h3);
        chk("busy_start_scalar", {32'h0, unit_scalar}, 64'hFFFF_FFFE);
        abort = 1'b1; idle(1); abort = 1'b0;
        idle(3);
        chk("abort_code_held", {61'h0, err_code}, 64'h4);

        // SCALAR_MUL then reset mid-wait: everything zero, no pulses.
        do_start(3'd3, 3'd2, 3'd0, 32'h1234_5678, s);
        push_us(5'b01000, s + 2);
        wait_to(s + 4);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", {unit_start, unit_id_a, unit_id_b, unit_scalar, busy, done, err, err_code},
            64'h0);
        idle(2);
        rst = 1'b0;
        idle(1);
        pulse(5'b01000, 5'b00000);
        idle(3);
        chk("post_reset_busy", {63'h0, busy}, 64'h0);

        // Recovery after reset.
        do_start(3'd1, 3'd1, 3'd4, 32'h0, s);
        push_us(5'b00010, s + 2);
        push_exp(1'b0, 3'd0, 3'd1, 3'd4, 32'h0, s + 4);
        wait_to(s + 3);
        pulse(5'b00010, 5'b00000);

        guard = 0;
        while ((exp_q.size() != 0 || us_q.size() != 0) && guard < 50) begin
            idle(1);
            guard++;
        end
        chk("outcomes_drained", 64'(exp_q.size()), 64'h0);
        chk("launches_drained", 64'(us_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
